// File: rtl/mult_pipeline_param.sv
// Pipelined WIDTH x WIDTH multiplier with joined AXI-Stream style operand inputs,
// per-transfer signed/unsigned mode and bubble-collapsing valid/ready stages.
module mult_pipeline_param #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     input_a_tdata,
   input  logic                 input_a_tvalid,
   output logic                 input_a_tready,
   input  logic [WIDTH-1:0]     input_b_tdata,
   input  logic                 input_b_tvalid,
   output logic                 input_b_tready,
   input  logic                 input_signed,
   output logic [2*WIDTH-1:0]   output_tdata,
   output logic                 output_tvalid,
   input  logic                 output_tready
);

   localparam int unsigned PW = 2 * WIDTH;

   logic [STAGES-1:0] valid_q, valid_d;
   logic [PW-1:0]     data_q [STAGES];
   logic [PW-1:0]     data_d [STAGES];
   logic              run_q, run_d;
   logic [STAGES:0]   adv;
   logic              accept;
   logic              xfer;
   logic [PW-1:0]     a_ext, b_ext, prod;

   // Extension to the full product width makes the modulo-2^PW product exact in both modes.
   always_comb begin
      a_ext = {{WIDTH{input_signed & input_a_tdata[WIDTH-1]}}, input_a_tdata};
      b_ext = {{WIDTH{input_signed & input_b_tdata[WIDTH-1]}}, input_b_tdata};
      prod  = a_ext * b_ext;
   end

   // A stage may load when it is empty or its contents move on this cycle.
   always_comb begin
      adv         = '0;
      adv[STAGES] = output_tready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         adv[k] = ~valid_q[k] | adv[k+1];
      end
   end

   always_comb begin
      run_d          = 1'b1;
      accept         = run_q & adv[0];
      input_a_tready = accept & input_b_tvalid;
      input_b_tready = accept & input_a_tvalid;
      xfer           = accept & input_a_tvalid & input_b_tvalid;
   end

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (adv[0]) begin
         valid_d[0] = xfer;
      end
      if (xfer) begin
         data_d[0] = prod;
      end
      for (int k = 1; k < STAGES; k++) begin
         if (adv[k]) begin
            valid_d[k] = valid_q[k-1];
            if (valid_q[k-1]) begin
               data_d[k] = data_q[k-1];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_q   <= 1'b0;
         valid_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            data_q[k] <= '0;
         end
      end else begin
         run_q   <= run_d;
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign output_tvalid = valid_q[STAGES-1];
   assign output_tdata  = data_q[STAGES-1];

endmodule

// File: tb/tb_mult_pipeline_param.sv
// Directed and randomized checks of mult_pipeline_param: default instance plus
// WIDTH=8/STAGES=1 and WIDTH=32/STAGES=5 instances against a reference product model.
module tb_mult_pipeline_param;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // default instance (WIDTH=16, STAGES=2)
   logic [15:0] a, b;
   logic        av, bv, ar, br, sgn, ov, otr;
   logic [31:0] od;

   // small instance (WIDTH=8, STAGES=1)
   logic [7:0]  s_a, s_b;
   logic        s_av, s_bv, s_ar, s_br, s_sgn, s_ov, s_otr;
   logic [15:0] s_od;

   // large instance (WIDTH=32, STAGES=5)
   logic [31:0] l_a, l_b;
   logic        l_av, l_bv, l_ar, l_br, l_sgn, l_ov, l_otr;
   logic [63:0] l_od;

   mult_pipeline_param dut (
      .clk(clk), .rst(rst),
      .input_a_tdata(a), .input_a_tvalid(av), .input_a_tready(ar),
      .input_b_tdata(b), .input_b_tvalid(bv), .input_b_tready(br),
      .input_signed(sgn),
      .output_tdata(od), .output_tvalid(ov), .output_tready(otr)
   );

   mult_pipeline_param #(.WIDTH(8), .STAGES(1)) dut_s (
      .clk(clk), .rst(rst),
      .input_a_tdata(s_a), .input_a_tvalid(s_av), .input_a_tready(s_ar),
      .input_b_tdata(s_b), .input_b_tvalid(s_bv), .input_b_tready(s_br),
      .input_signed(s_sgn),
      .output_tdata(s_od), .output_tvalid(s_ov), .output_tready(s_otr)
   );

   mult_pipeline_param #(.WIDTH(32), .STAGES(5)) dut_l (
      .clk(clk), .rst(rst),
      .input_a_tdata(l_a), .input_a_tvalid(l_av), .input_a_tready(l_ar),
      .input_b_tdata(l_b), .input_b_tvalid(l_bv), .input_b_tready(l_br),
      .input_signed(l_sgn),
      .output_tdata(l_od), .output_tvalid(l_ov), .output_tready(l_otr)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: interpret operands as w-bit values, multiply exactly, keep 2w bits.
   function automatic logic [63:0] ref_mul(input int w, input logic [63:0] x, input logic [63:0] y,
                                           input logic s);
      logic signed [127:0] one, xe, ye, p, msk;
      one = 128'sd1;
      xe  = '0;
      ye  = '0;
      xe[63:0] = x;
      ye[63:0] = y;
      xe = xe & ((one <<< w) - one);
      ye = ye & ((one <<< w) - one);
      if (s && x[w-1]) xe = xe - (one <<< w);
      if (s && y[w-1]) ye = ye - (one <<< w);
      p   = xe * ye;
      msk = (one <<< (2 * w)) - one;
      p   = p & msk;
      return p[63:0];
   endfunction

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sgn;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int lat, cnt, idx_in, idx_out, seen;
      logic [63:0] s_q[$];
      logic [63:0] l_q[$];
      int          s_tq[$];
      int          l_tq[$];
      int          s_tx, s_rx, l_tx, l_rx;
      logic [63:0] e;
      bit          stale;

      vecs[0] = '{16'd690,  16'd2137, 1'b0, 32'd1474530};
      vecs[1] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
      vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001};
      vecs[3] = '{16'hFFFF, 16'd2,    1'b1, 32'hFFFFFFFE};
      vecs[4] = '{16'h8000, 16'h8000, 1'b1, 32'h40000000};
      vecs[5] = '{16'h8000, 16'h7FFF, 1'b1, 32'hC0008000};
      vecs[6] = '{16'h8000, 16'h7FFF, 1'b0, 32'h3FFF8000};
      vecs[7] = '{16'h0000, 16'hFFFF, 1'b1, 32'h00000000};
      vecs[8] = '{16'h1234, 16'h0010, 1'b0, 32'h00012340};
      vecs[9] = '{16'hFFFD, 16'd5,    1'b1, 32'hFFFFFFF1};

      rst = 1'b0;
      a = '0; b = '0; av = 1'b1; bv = 1'b1; sgn = 1'b0; otr = 1'b1;
      s_a = '0; s_b = '0; s_av = 1'b0; s_bv = 1'b0; s_sgn = 1'b0; s_otr = 1'b1;
      l_a = '0; l_b = '0; l_av = 1'b0; l_bv = 1'b0; l_sgn = 1'b0; l_otr = 1'b1;

      // Reset state with valids asserted
      #12;
      check("rst_tvalid", 64'(ov), 64'd0);
      check("rst_tdata", 64'(od), 64'd0);
      check("rst_a_tready", 64'(ar), 64'd0);
      check("rst_b_tready", 64'(br), 64'd0);
      av = 1'b0; bv = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Directed vectors, one isolated transfer each with latency measurement
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         a = vecs[i].a; b = vecs[i].b; sgn = vecs[i].sgn; av = 1'b1; bv = 1'b1; otr = 1'b1;
         #1;
         check($sformatf("vec%0d_tready", i), 64'(ar & br), 64'd1);
         @(negedge clk);
         av = 1'b0; bv = 1'b0;
         lat = 1;
         while (!ov && lat < 20) begin
            @(negedge clk);
            lat++;
         end
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
         check($sformatf("vec%0d_product", i), 64'(od), 64'(vecs[i].exp));
      end
      @(negedge clk);

      // Back-pressure: 5 pairs, output stalled cycles 2..10
      idx_in = 0; idx_out = 0;
      for (int c = 0; c < 40 && idx_out < 5; c++) begin
         @(negedge clk);
         otr = !(c >= 2 && c <= 10);
         av  = (idx_in < 5); bv = av; sgn = 1'b0;
         a   = 16'(idx_in + 1); b = 16'(idx_in + 1);
         #1;
         if (c >= 2 && c <= 10) begin
            check($sformatf("bp_tready_low_c%0d", c), 64'(ar | br), 64'd0);
            check($sformatf("bp_hold_c%0d", c), 64'({ov, od}), {31'd0, 1'b1, 32'd1});
         end
         if (c == 11) check("bp_full_accept", 64'(ar & br), 64'd1);
         if (c >= 11) check($sformatf("bp_no_gap_c%0d", c), 64'(ov), 64'd1);
         if (ov && otr) begin
            check($sformatf("bp_out%0d", idx_out), 64'(od), 64'((idx_out + 1) * (idx_out + 1)));
            idx_out++;
         end
         if (av && bv && ar && br) idx_in++;
      end
      check("bp_count", 64'(idx_out), 64'd5);
      @(negedge clk);
      av = 1'b0; bv = 1'b0; otr = 1'b1;
      repeat (3) @(negedge clk);

      // Unjoined valids: A alone for 3 cycles, then B joins
      a = 16'd7; b = 16'd9; sgn = 1'b0; av = 1'b1; bv = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("unj_a_tready_c%0d", c), 64'(ar), 64'd0);
         check($sformatf("unj_no_out_c%0d", c), 64'(ov), 64'd0);
         @(negedge clk);
      end
      bv = 1'b1;
      #1;
      check("unj_joined_tready", 64'(ar & br), 64'd1);
      @(negedge clk);
      av = 1'b0; bv = 1'b0;
      cnt = 0; seen = 0;
      for (int c = 0; c < 8; c++) begin
         if (ov) begin
            cnt++;
            seen = int'(od);
         end
         @(negedge clk);
      end
      check("unj_count", 64'(cnt), 64'd1);
      check("unj_product", 64'(seen), 64'd63);

      // Reset mid-flight with two products in the pipe
      a = 16'd3; b = 16'd3; av = 1'b1; bv = 1'b1; otr = 1'b1;
      @(negedge clk);
      a = 16'd4; b = 16'd4;
      @(negedge clk);
      av = 1'b0; bv = 1'b0; otr = 1'b0;
      #1;
      check("mid_inflight", 64'(ov), 64'd1);
      rst = 1'b0;
      #1;
      check("mid_rst_tvalid", 64'(ov), 64'd0);
      check("mid_rst_tdata", 64'(od), 64'd0);
      check("mid_rst_tready", 64'(ar | br), 64'd0);
      @(negedge clk);
      rst = 1'b1; av = 1'b1; bv = 1'b1; a = 16'd0; b = 16'd0;
      #1;
      check("rel_tready_before_edge", 64'(ar | br), 64'd0);
      @(posedge clk);
      #1;
      check("rel_tready_after_edge", 64'(ar & br), 64'd1);
      @(negedge clk);
      av = 1'b0; bv = 1'b0; otr = 1'b1;
      stale = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (ov) stale = 1'b1;
      end
      check("mid_no_stale", 64'(stale), 64'd0);

      // Randomized sweep on the two non-default instances, run concurrently
      s_tx = 0; s_rx = 0; l_tx = 0; l_rx = 0;
      for (int cyc = 0; cyc < 20000 && (s_rx < 1000 || l_rx < 1000); cyc++) begin
         @(negedge clk);
         s_av = (s_tx < 1000) && ($urandom_range(0, 3) != 0);
         s_bv = (s_tx < 1000) && ($urandom_range(0, 3) != 0);
         s_a = 8'($urandom); s_b = 8'($urandom); s_sgn = 1'($urandom);
         s_otr = ($urandom_range(0, 3) != 0);
         l_av = (l_tx < 1000) && ($urandom_range(0, 3) != 0);
         l_bv = (l_tx < 1000) && ($urandom_range(0, 3) != 0);
         l_a = $urandom; l_b = $urandom; l_sgn = 1'($urandom);
         l_otr = ($urandom_range(0, 3) != 0);
         if ((cyc % 97) < 6) begin
            s_a = 8'h80 | 8'($urandom_range(0, 1));
            l_a = 32'hFFFFFFFF;
         end
         #1;
         if (s_ov) begin
            e = (s_q.size() > 0) ? s_q[0] : 64'hDEAD;
            check("sw8_product", 64'(s_od), e);
            if (s_otr) begin
               if (s_q.size() > 0) begin
                  void'(s_q.pop_front());
                  check("sw8_latency_min", 64'(cyc - s_tq.pop_front() >= 1), 64'd1);
               end
               s_rx++;
            end
         end
         if (s_av && s_bv && s_ar && s_br) begin
            s_q.push_back(ref_mul(8, 64'(s_a), 64'(s_b), s_sgn));
            s_tq.push_back(cyc);
            s_tx++;
         end
         if (l_ov) begin
            e = (l_q.size() > 0) ? l_q[0] : 64'hDEAD;
            check("sw32_product", l_od, e);
            if (l_otr) begin
               if (l_q.size() > 0) begin
                  void'(l_q.pop_front());
                  check("sw32_latency_min", 64'(cyc - l_tq.pop_front() >= 5), 64'd1);
               end
               l_rx++;
            end
         end
         if (l_av && l_bv && l_ar && l_br) begin
            l_q.push_back(ref_mul(32, 64'(l_a), 64'(l_b), l_sgn));
            l_tq.push_back(cyc);
            l_tx++;
         end
      end
      check("sw8_count", 64'(s_rx), 64'd1000);
      check("sw32_count", 64'(l_rx), 64'd1000);

      // Exact unstalled latency on the 5-stage instance
      @(negedge clk);
      l_av = 1'b1; l_bv = 1'b1; l_a = 32'hFFFFFFFF; l_b = 32'h00000003; l_sgn = 1'b1; l_otr = 1'b1;
      s_av = 1'b0; s_bv = 1'b0; s_otr = 1'b1;
      @(negedge clk);
      l_av = 1'b0; l_bv = 1'b0;
      lat = 1;
      while (!l_ov && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("sw32_exact_latency", 64'(lat), 64'd5);
      check("sw32_exact_product", l_od, 64'hFFFFFFFFFFFFFFFD);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mult_pipeline_param.md
MULT_PIPELINE_PARAM -- requirements
Module: mult_pipeline_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand width in bits (legal 2..64).
REQ-002 The block SHALL have parameter STAGES, default 2, number of pipeline register stages (legal 1..8).
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 The block SHALL have port input_a_tdata  input  WIDTH  operand A.
REQ-006 The block SHALL have port input_a_tvalid  input  1  operand A valid.
REQ-007 The block SHALL have port input_a_tready  output  1  operand A accepted this cycle when high with tvalid.
REQ-008 The block SHALL have port input_b_tdata  input  WIDTH  operand B.
REQ-009 The block SHALL have port input_b_tvalid  input  1  operand B valid.
REQ-010 The block SHALL have port input_b_tready  output  1  operand B accepted this cycle when high with tvalid.
REQ-011 The block SHALL have port input_signed  input  1  mode, sampled with the operands: 1 = two's-complement, 0 = unsigned.
REQ-012 The block SHALL have port output_tdata  output  2*WIDTH  product.
REQ-013 The block SHALL have port output_tvalid  output  1  product valid.
REQ-014 The block SHALL have port output_tready  input  1  downstream ready.

Function
REQ-015 The block SHALL join the A and B streams: a transfer occurs only when input_a_tvalid, input_b_tvalid and the internal accept condition are all high in the same cycle.
REQ-016 The block SHALL drive input_a_tready = accept & input_b_tvalid and input_b_tready = accept & input_a_tvalid, so that neither operand is consumed alone.
REQ-017 The block SHALL set accept high when stage 1 is empty or stage 1 advances in the same cycle.
REQ-018 The block SHALL hold one valid bit per stage; stage k SHALL advance when stage k+1 is empty or advancing, and the last stage SHALL advance when output_tready is high.
REQ-019 The block SHALL collapse bubbles: an empty stage SHALL accept data from the previous stage even while a later stage is stalled.
REQ-020 The block SHALL sample input_signed with the operands and carry it with the data; the mode applies per transfer.
REQ-021 The block SHALL compute the full 2*WIDTH-bit product with no truncation or overflow: signed mode sign-extends both operands; unsigned mode zero-extends.
REQ-022 The block SHALL present the result of a transfer on output_tdata with output_tvalid high exactly STAGES cycles after the transfer edge when output_tready stays high.
REQ-023 The block SHALL sustain a throughput of one product per cycle under continuous valid/ready.
REQ-024 The block SHALL preserve result order, with no loss or duplication.
REQ-025 The block SHALL hold output_tdata stable while output_tvalid is high and output_tready is low.
REQ-026 The block SHALL keep output_tvalid high until a handshake completes.
REQ-027 When output_tvalid and output_tready are high and stage STAGES-1 is valid, the next product SHALL appear on the following cycle with no bubble.
REQ-028 When the pipeline is full and stalled, the block SHALL hold both treadys low.
REQ-029 When the pipeline is full and output_tready is high in a cycle, the block SHALL accept a new operand pair in that same cycle.

Reset
REQ-030 While rst = 0, the block SHALL immediately clear all stage valid bits, output_tvalid, input_a_tready and input_b_tready, independent of clk.
REQ-031 While rst = 0, the block SHALL force output_tdata to 0.
REQ-032 The block SHALL discard in-flight products when reset is asserted mid-operation and SHALL never emit them afterwards.
REQ-033 After rst is released, the block SHALL raise the treadys on the first rising edge, given operand valids.

Verification
REQ-034 Unsigned product, latency check: defaults, input_signed=0, A=690, B=2137, both valid, output_tready=1 -> output_tdata=1474530 (0x00167FE2), output_tvalid high exactly 2 cycles after the transfer edge.
REQ-035 Width and mode extremes: A=0xFFFF, B=0xFFFF -> 0xFFFE0001 when unsigned and 0x00000001 when signed; A=0xFFFF (-1), B=2, signed -> 0xFFFFFFFE.
REQ-036 Back-pressure: stream 5 pairs (1*1..5*5) with output_tready=0 from cycle 2 to cycle 10 -> the first product (1) is held stable, the treadys drop once 2 stages are full, then the outputs are 1,4,9,16,25 in order with no gaps after release.
REQ-037 Unjoined valids: A valid only for 3 cycles, then B valid -> input_a_tready stays low and no transfer occurs until both are valid; exactly one product is produced.
REQ-038 Reset mid-flight: assert rst=0 for 1 cycle while 2 products are in flight -> output_tvalid=0 and output_tdata=0 immediately, and no stale product appears after release.
REQ-039 Parameter sweep: WIDTH=8, STAGES=1 and WIDTH=32, STAGES=5 with 1000 random pairs and random output_tready, in both signed and unsigned modes -> outputs match a reference model, with latency equal to STAGES when unstalled.
